updown_count_sequencer: RTL and testbench



---
 rtl/updown_count_sequencer_if.sv | 30 +++
 rtl/updown_count_sequencer.sv | 143 ++++++++++++++
 tb/tb_updown_count_sequencer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/updown_count_sequencer_if.sv
// Control/status bundle for the up/down count sequencer.
// The slave modport is the sequencer; the master modport is whoever drives it.
interface updown_count_sequencer_if #(
   parameter int N = 8,
   parameter int R = 4
);
   logic         start;
   logic         stop;
   logic         pause;
   logic [1:0]   mode;
   logic [N-1:0] lo;
   logic [N-1:0] hi;
   logic [R-1:0] reps;
   logic [N-1:0] count;
   logic         dir;
   logic         busy;
   logic         done;
   logic         wrap;
   logic         err;

   modport master (
      output start, stop, pause, mode, lo, hi, reps,
      input  count, dir, busy, done, wrap, err
   );

   modport slave (
      input  start, stop, pause, mode, lo, hi, reps,
      output count, dir, busy, done, wrap, err
   );
endinterface

// File: rtl/updown_count_sequencer.sv
// Run controller for a bounded up/down count register: one-shot up/down,
// ping-pong over a number of round trips, and free-running auto-reload.
module updown_count_sequencer #(
   parameter int N = 8,
   parameter int R = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   updown_count_sequencer_if.slave bus
);
   typedef enum logic {IDLE, RUN} state_t;

   state_t       r_state;
   logic [1:0]   r_mode;
   logic [N-1:0] r_lo;
   logic [N-1:0] r_hi;
   logic [R-1:0] r_rem;
   logic [N-1:0] r_count;
   logic         r_dir;
   logic         r_busy;
   logic         r_done;
   logic         r_wrap;
   logic         r_err;

   logic w_at_hi;
   logic w_at_lo;

   assign w_at_hi = (r_count == r_hi);
   assign w_at_lo = (r_count == r_lo);

   assign bus.count = r_count;
   assign bus.dir   = r_dir;
   assign bus.busy  = r_busy;
   assign bus.done  = r_done;
   assign bus.wrap  = r_wrap;
   assign bus.err   = r_err;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_mode  <= '0;
         r_lo    <= '0;
         r_hi    <= '0;
         r_rem   <= '0;
         r_count <= '0;
         r_dir   <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_wrap  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_wrap <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  if (bus.lo > bus.hi) begin
                     r_err <= 1'b1;
                  end else begin
                     r_mode  <= bus.mode;
                     r_lo    <= bus.lo;
                     r_hi    <= bus.hi;
                     r_rem   <= (bus.reps == '0) ? R'(1) : bus.reps;
                     r_busy  <= 1'b1;
                     r_state <= RUN;
                     if (bus.mode == 2'd1) begin
                        r_count <= bus.hi;
                        r_dir   <= 1'b0;
                     end else begin
                        r_count <= bus.lo;
                        r_dir   <= 1'b1;
                     end
                  end
               end
            end
            RUN: begin
               if (bus.stop) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else if (!bus.pause) begin
                  case (r_mode)
                     2'd0: begin
                        if (w_at_hi) begin
                           r_state <= IDLE;
                           r_busy  <= 1'b0;
                           r_done  <= 1'b1;
                        end else begin
                           r_count <= r_count + 1'b1;
                        end
                     end
                     2'd1: begin
                        if (w_at_lo) begin
                           r_state <= IDLE;
                           r_busy  <= 1'b0;
                           r_done  <= 1'b1;
                        end else begin
                           r_count <= r_count - 1'b1;
                        end
                     end
                     2'd2: begin
                        // lo==hi has no room to turn around, so it completes at once
                        if (r_dir) begin
                           if (w_at_hi && w_at_lo) begin
                              r_state <= IDLE;
                              r_busy  <= 1'b0;
                              r_done  <= 1'b1;
                           end else if (w_at_hi) begin
                              r_dir   <= 1'b0;
                              r_count <= r_count - 1'b1;
                           end else begin
                              r_count <= r_count + 1'b1;
                           end
                        end else begin
                           if (w_at_lo && (r_rem > R'(1))) begin
                              r_rem   <= r_rem - 1'b1;
                              r_dir   <= 1'b1;
                              r_count <= r_lo + 1'b1;
                           end else if (w_at_lo) begin
                              r_state <= IDLE;
                              r_busy  <= 1'b0;
                              r_done  <= 1'b1;
                           end else begin
                              r_count <= r_count - 1'b1;
                           end
                        end
                     end
                     default: begin
                        if (w_at_hi) begin
                           r_count <= r_lo;
                           r_wrap  <= 1'b1;
                        end else begin
                           r_count <= r_count + 1'b1;
                        end
                     end
                  endcase
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_updown_count_sequencer.sv
// Directed bench for updown_count_sequencer: one task per scenario, inline checks.
module tb_updown_count_sequencer;
   logic clk;
   logic reset;
   int   n_cmp;
   int   n_fail;

   updown_count_sequencer_if #(.N(8), .R(4)) bus ();

   updown_count_sequencer #(.N(8), .R(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [1:0] m, input logic [7:0] l, input logic [7:0] h, input logic [3:0] r);
      bus.mode  = m;
      bus.lo    = l;
      bus.hi    = h;
      bus.reps  = r;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      int dones;
      reset = 1'b1;
      #12;
      n_cmp++; if (bus.count !== 8'd0) begin n_fail++; $display("FAIL rst_count got=%0d exp=0", bus.count); end
      n_cmp++; if (bus.dir !== 1'b1) begin n_fail++; $display("FAIL rst_dir got=%b exp=1", bus.dir); end
      n_cmp++; if ({bus.busy, bus.done, bus.wrap, bus.err} !== 4'b0) begin n_fail++; $display("FAIL rst_flags got=%b exp=0000", {bus.busy, bus.done, bus.wrap, bus.err}); end
      @(negedge clk);
      reset = 1'b0;
      #1;
      do_start(2'd0, 8'd0, 8'd20, 4'd0);
      for (int i = 0; i < 5; i++) tick();
      n_cmp++; if (bus.count !== 8'd5) begin n_fail++; $display("FAIL rst_mid_pre count got=%0d exp=5", bus.count); end
      reset = 1'b1;
      #1;
      n_cmp++; if (bus.count !== 8'd0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid count=%0d busy=%b exp 0/0", bus.count, bus.busy); end
      dones = 0;
      for (int i = 0; i < 3; i++) begin tick(); if (bus.done) dones++; end
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin tick(); if (bus.done) dones++; end
      n_cmp++; if (dones !== 0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_nodone dones=%0d busy=%b exp 0/0", dones, bus.busy); end
   endtask

   task automatic test_mode0();
      logic [7:0] ec [4] = '{8'd4, 8'd5, 8'd6, 8'd6};
      do_start(2'd0, 8'd3, 8'd6, 4'd0);
      n_cmp++; if (bus.count !== 8'd3 || bus.busy !== 1'b1 || bus.dir !== 1'b1) begin n_fail++; $display("FAIL m0_start count=%0d busy=%b dir=%b exp 3/1/1", bus.count, bus.busy, bus.dir); end
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++; if (bus.count !== ec[i] || bus.done !== (i == 3) || bus.busy !== (i != 3)) begin n_fail++; $display("FAIL m0_edge%0d count=%0d done=%b busy=%b exp %0d/%b/%b", i+1, bus.count, bus.done, bus.busy, ec[i], (i == 3), (i != 3)); end
      end
      tick();
      n_cmp++; if (bus.done !== 1'b0 || bus.count !== 8'd6) begin n_fail++; $display("FAIL m0_after done=%b count=%0d exp 0/6", bus.done, bus.count); end
   endtask

   task automatic test_mode1_pause();
      logic [7:0] ec [7] = '{8'd4, 8'd4, 8'd4, 8'd4, 8'd3, 8'd2, 8'd2};
      do_start(2'd1, 8'd2, 8'd5, 4'd0);
      n_cmp++; if (bus.count !== 8'd5 || bus.dir !== 1'b0) begin n_fail++; $display("FAIL m1_start count=%0d dir=%b exp 5/0", bus.count, bus.dir); end
      for (int i = 0; i < 7; i++) begin
         bus.pause = (i >= 1 && i <= 3);
         tick();
         n_cmp++; if (bus.count !== ec[i] || bus.done !== (i == 6)) begin n_fail++; $display("FAIL m1_edge%0d count=%0d done=%b exp %0d/%b", i+1, bus.count, bus.done, ec[i], (i == 6)); end
      end
      bus.pause = 1'b0;
      n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL m1_busy got=%b exp=0", bus.busy); end
   endtask

   task automatic test_mode2();
      logic [7:0] ec [9] = '{8'd1, 8'd2, 8'd1, 8'd0, 8'd1, 8'd2, 8'd1, 8'd0, 8'd0};
      logic       ed [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      int dones;
      dones = 0;
      do_start(2'd2, 8'd0, 8'd2, 4'd2);
      for (int i = 0; i < 9; i++) begin
         tick();
         if (bus.done) dones++;
         n_cmp++; if (bus.count !== ec[i] || bus.done !== (i == 8)) begin n_fail++; $display("FAIL m2_edge%0d count=%0d done=%b exp %0d/%b", i+1, bus.count, bus.done, ec[i], (i == 8)); end
         if (i < 8) begin
            n_cmp++; if (bus.dir !== ed[i]) begin n_fail++; $display("FAIL m2_dir%0d got=%b exp=%b", i+1, bus.dir, ed[i]); end
         end
      end
      tick();
      if (bus.done) dones++;
      n_cmp++; if (dones !== 1) begin n_fail++; $display("FAIL m2_done_count got=%0d exp=1", dones); end
   endtask

   task automatic test_reps_zero();
      logic [7:0] ec [3] = '{8'd1, 8'd0, 8'd0};
      do_start(2'd2, 8'd0, 8'd1, 4'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if (bus.count !== ec[i] || bus.done !== (i == 2)) begin n_fail++; $display("FAIL rep0_edge%0d count=%0d done=%b exp %0d/%b", i+1, bus.count, bus.done, ec[i], (i == 2)); end
      end
   endtask

   task automatic test_mode3_stop();
      do_start(2'd3, 8'd254, 8'd255, 4'd0);
      n_cmp++; if (bus.count !== 8'd254) begin n_fail++; $display("FAIL m3_start count=%0d exp=254", bus.count); end
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++; if (bus.count !== ((i % 2 == 0) ? 8'd255 : 8'd254) || bus.wrap !== (i % 2 == 1) || bus.done !== 1'b0) begin n_fail++; $display("FAIL m3_edge%0d count=%0d wrap=%b done=%b", i+1, bus.count, bus.wrap, bus.done); end
      end
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
      n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.wrap !== 1'b0 || bus.count !== 8'd254) begin n_fail++; $display("FAIL m3_stop busy=%b done=%b wrap=%b count=%0d exp 0/0/0/254", bus.busy, bus.done, bus.wrap, bus.count); end
      tick();
      n_cmp++; if (bus.count !== 8'd254 || bus.done !== 1'b0) begin n_fail++; $display("FAIL m3_idle count=%0d done=%b exp 254/0", bus.count, bus.done); end
   endtask

   task automatic test_err_and_equal();
      do_start(2'd0, 8'd7, 8'd3, 4'd0);
      n_cmp++; if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.count !== 8'd254) begin n_fail++; $display("FAIL err_pulse err=%b busy=%b count=%0d exp 1/0/254", bus.err, bus.busy, bus.count); end
      tick();
      n_cmp++; if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL err_clear err=%b busy=%b exp 0/0", bus.err, bus.busy); end
      do_start(2'd0, 8'd9, 8'd9, 4'd0);
      n_cmp++; if (bus.count !== 8'd9 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL eq0_start count=%0d busy=%b exp 9/1", bus.count, bus.busy); end
      tick();
      n_cmp++; if (bus.done !== 1'b1 || bus.count !== 8'd9 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL eq0_done done=%b count=%0d busy=%b exp 1/9/0", bus.done, bus.count, bus.busy); end
      do_start(2'd2, 8'd3, 8'd3, 4'd5);
      tick();
      n_cmp++; if (bus.done !== 1'b1 || bus.count !== 8'd3) begin n_fail++; $display("FAIL eq2_done done=%b count=%0d exp 1/3", bus.done, bus.count); end
      do_start(2'd3, 8'd40, 8'd40, 4'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if (bus.wrap !== 1'b1 || bus.count !== 8'd40 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL eq3_edge%0d wrap=%b count=%0d busy=%b exp 1/40/1", i+1, bus.wrap, bus.count, bus.busy); end
      end
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
   endtask

   task automatic test_back_to_back();
      do_start(2'd0, 8'd1, 8'd2, 4'd0);
      tick();
      tick();
      n_cmp++; if (bus.done !== 1'b1 || bus.count !== 8'd2) begin n_fail++; $display("FAIL b2b_done1 done=%b count=%0d exp 1/2", bus.done, bus.count); end
      do_start(2'd0, 8'd4, 8'd5, 4'd0);
      n_cmp++; if (bus.count !== 8'd4 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin n_fail++; $display("FAIL b2b_restart count=%0d busy=%b done=%b exp 4/1/0", bus.count, bus.busy, bus.done); end
      bus.start = 1'b1;
      bus.lo    = 8'd0;
      tick();
      bus.start = 1'b0;
      n_cmp++; if (bus.count !== 8'd5 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_ignore_start count=%0d busy=%b exp 5/1", bus.count, bus.busy); end
      tick();
      n_cmp++; if (bus.done !== 1'b1 || bus.count !== 8'd5) begin n_fail++; $display("FAIL b2b_done2 done=%b count=%0d exp 1/5", bus.done, bus.count); end
   endtask

   initial begin
      n_cmp     = 0;
      n_fail    = 0;
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      bus.pause = 1'b0;
      bus.mode  = 2'd0;
      bus.lo    = 8'd0;
      bus.hi    = 8'd0;
      bus.reps  = 4'd0;
      test_reset();
      test_mode0();
      test_mode1_pause();
      test_mode2();
      test_reps_zero();
      test_mode3_stop();
      test_err_and_equal();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
